// File: rtl/hazard_unit.sv
// hazard_unit: pipeline sequencing controller for the five-stage core.
// Keeps a shadow copy of the EX/MEM/WB destination and source registers.
// From that copy it drives the stage-register enables and flushes, the EX
// forwarding selects and the data-memory req/gnt/rvalid handshake.
// Ports:
//   clk_i, rst_ni              core clock, async active-low reset
//   id_*                       decode info of the instruction currently in ID
//   id_jump_i, ex_redirect_i   JAL resolved in ID / branch or JALR taken in EX
//   dmem_gnt_i, dmem_rvalid_i  data-memory grant and load-data valid
//   dmem_req_o                 data-memory request
//   *_we_o, *_flush_o          stage-register enables and bubble loads
//   fwd_a_o, fwd_b_o           EX operand select: 0 regfile, 1 MEM ALU, 2 WB
// All outputs are combinational from internal state plus current inputs.
module hazard_unit #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic                  id_load_i,
  input  logic                  id_store_i,
  input  logic                  id_jump_i,
  input  logic                  ex_redirect_i,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  output logic                  dmem_req_o,
  output logic                  pc_we_o,
  output logic                  if_id_we_o,
  output logic                  id_ex_we_o,
  output logic                  ex_mem_we_o,
  output logic                  mem_wb_we_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  we;
    logic                  load;
    logic                  store;
  } stage_t;

  typedef struct packed {
    stage_t                info;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } ex_stage_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

  ex_stage_t  ex_q, ex_d;
  stage_t     mem_q, wb_q;
  mem_state_e mem_state_q, mem_state_d;
  logic       memop;
  logic       mem_stall;
  logic       load_use;
  logic       bubble;

  // Operand source for one EX register index; MEM wins over WB, x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] rs,
                                         input stage_t mem, input stage_t wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (rs != '0) begin
      if (mem.valid && mem.we && !mem.load && mem.rd == rs) begin
        sel = 2'd1;
      end else if (wb.valid && wb.we && wb.rd == rs) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  assign memop = mem_q.valid && (mem_q.load || mem_q.store);

  // Data-memory handshake: next state, request and pipeline freeze
  always_comb begin
    mem_state_d = mem_state_q;
    dmem_req_o  = 1'b0;
    mem_stall   = 1'b0;
    case (mem_state_q)
      IDLE: begin
        if (memop) begin
          dmem_req_o = 1'b1;
          if (!dmem_gnt_i) begin
            mem_state_d = WAIT_GNT;
            mem_stall   = 1'b1;
          end else if (mem_q.load) begin
            mem_state_d = WAIT_RVALID;
            mem_stall   = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        dmem_req_o = 1'b1;
        if (!dmem_gnt_i) begin
          mem_stall = 1'b1;
        end else if (mem_q.load) begin
          mem_state_d = WAIT_RVALID;
          mem_stall   = 1'b1;
        end else begin
          mem_state_d = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          mem_state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: mem_state_d = IDLE;
    endcase
  end

  assign load_use = ex_q.info.valid && ex_q.info.load && (ex_q.info.rd != '0) && id_valid_i &&
                    ((id_rs1_used_i && id_rs1_i == ex_q.info.rd) ||
                     (id_rs2_used_i && id_rs2_i == ex_q.info.rd));
  assign bubble   = load_use || ex_redirect_i;

  // Stage enables and flushes; a redirect outranks load-use, which outranks a jump
  always_comb begin
    pc_we_o       = 1'b1;
    if_id_we_o    = 1'b1;
    id_ex_we_o    = 1'b1;
    ex_mem_we_o   = 1'b1;
    mem_wb_we_o   = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (rst_ni) begin
      if (mem_stall) begin
        pc_we_o     = 1'b0;
        if_id_we_o  = 1'b0;
        id_ex_we_o  = 1'b0;
        ex_mem_we_o = 1'b0;
        mem_wb_we_o = 1'b0;
      end else if (ex_redirect_i) begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end else if (load_use) begin
        pc_we_o       = 1'b0;
        if_id_we_o    = 1'b0;
        id_ex_flush_o = 1'b1;
      end else if (id_jump_i) begin
        if_id_flush_o = 1'b1;
      end
    end
  end

  assign fwd_a_o = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign fwd_b_o = fwd_sel(ex_q.rs2, mem_q, wb_q);

  // Next EX shadow entry: the ID instruction, or an all-zero bubble
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.info.valid = id_valid_i;
      ex_d.info.rd    = id_rd_i;
      ex_d.info.we    = id_we_i;
      ex_d.info.load  = id_load_i;
      ex_d.info.store = id_store_i;
      ex_d.rs1        = id_rs1_i;
      ex_d.rs2        = id_rs2_i;
      ex_d.rs1_used   = id_rs1_used_i;
      ex_d.rs2_used   = id_rs2_used_i;
    end
  end

  // Shadow pipeline advances whenever memory is not holding the core
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q.info;
      ex_q  <= ex_d;
    end
  end

  // Memory FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_state_q <= IDLE;
    end else begin
      mem_state_q <= mem_state_d;
    end
  end

  // Tracked for debug visibility; not needed by any decision
  logic unused_shadow;
  assign unused_shadow = ^{ex_q.rs1_used, ex_q.rs2_used, wb_q.load, wb_q.store};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: a directed vector table plus a reset sequence, then
// random traffic, all checked against a behavioural pipeline model.
module tb_hazard_unit;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_ni;
  logic          id_valid, id_rs1_used, id_rs2_used, id_we, id_load, id_store;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_jump, ex_redirect, dmem_gnt, dmem_rvalid;
  logic          dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic          if_id_flush, id_ex_flush;
  logic [1:0]    fwd_a, fwd_b;

  hazard_unit #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load), .id_store_i(id_store),
    .id_jump_i(id_jump), .ex_redirect_i(ex_redirect),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_req_o(dmem_req), .pc_we_o(pc_we), .if_id_we_o(if_id_we),
    .id_ex_we_o(id_ex_we), .ex_mem_we_o(ex_mem_we), .mem_wb_we_o(mem_wb_we),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; int rd; int rs1; int rs2; bit u1; bit u2;
    bit we; bit ld; bit st; bit jmp; bit redir; bit gnt; bit rvalid;
  } stim_t;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex}
  typedef struct packed {
    logic req; logic [4:0] en; logic [1:0] fl; logic [1:0] fa; logic [1:0] fb;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  typedef struct { bit v; int rd; bit we; bit ld; bit st; int rs1; int rs2; } ins_t;

  localparam logic [4:0] ALL  = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LU   = 5'b00111;

  int checks = 0;
  int errors = 0;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; granted = MEM load already accepted
  ins_t pipe [3];
  bit   granted;

  function automatic stim_t ins(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit we,
                                bit ld, bit st, bit jmp, bit redir, bit gnt, bit rvalid);
    stim_t s;
    s.v = v; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.we = we;
    s.ld = ld; s.st = st; s.jmp = jmp; s.redir = redir; s.gnt = gnt; s.rvalid = rvalid;
    return s;
  endfunction

  function automatic stim_t nop(bit gnt, bit rvalid);
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, gnt, rvalid);
  endfunction

  function automatic exp_t ex(logic req, logic [4:0] en, logic [1:0] fl, logic [1:0] fa, logic [1:0] fb);
    exp_t e;
    e.req = req; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_rd = AW'(s.rd); id_rs1 = AW'(s.rs1); id_rs2 = AW'(s.rs2);
    id_rs1_used = s.u1; id_rs2_used = s.u2; id_we = s.we; id_load = s.ld; id_store = s.st;
    id_jump = s.jmp; ex_redirect = s.redir; dmem_gnt = s.gnt; dmem_rvalid = s.rvalid;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".req"}, 8'(dmem_req), 8'(e.req));
    chk({tag, ".en"}, 8'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 8'(e.en));
    chk({tag, ".flush"}, 8'({if_id_flush, id_ex_flush}), 8'(e.fl));
    chk({tag, ".fwd_a"}, 8'(fwd_a), 8'(e.fa));
    chk({tag, ".fwd_b"}, 8'(fwd_b), 8'(e.fb));
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    granted = 0;
  endfunction

  function automatic int fwd(int rs);
    if (rs == 0) return 0;
    if (pipe[1].v && pipe[1].we && !pipe[1].ld && pipe[1].rd == rs) return 1;
    if (pipe[2].v && pipe[2].we && pipe[2].rd == rs) return 2;
    return 0;
  endfunction

  function automatic bit m_memop();
    return pipe[1].v && (pipe[1].ld || pipe[1].st);
  endfunction

  // A memory op holds the core until a store is granted or a granted load sees rvalid
  function automatic bit m_stall(stim_t s);
    if (!m_memop()) return 0;
    if (granted) return !s.rvalid;
    return !(s.gnt && !pipe[1].ld);
  endfunction

  function automatic bit m_lu(stim_t s);
    return pipe[0].v && pipe[0].ld && pipe[0].rd != 0 && s.v &&
           ((s.u1 && s.rs1 == pipe[0].rd) || (s.u2 && s.rs2 == pipe[0].rd));
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    e.req = m_memop() && !granted;
    e.en  = ALL;
    e.fl  = 2'b00;
    if (m_stall(s))    e.en = NONE;
    else if (s.redir)  e.fl = 2'b11;
    else if (m_lu(s))  begin e.en = LU; e.fl = 2'b01; end
    else if (s.jmp)    e.fl = 2'b10;
    e.fa = 2'(fwd(pipe[0].rs1));
    e.fb = 2'(fwd(pipe[0].rs2));
    return e;
  endfunction

  function automatic void model_update(stim_t s);
    bit stall, lu;
    stall = m_stall(s);
    lu    = m_lu(s);
    if (m_memop() && !granted && s.gnt && pipe[1].ld) granted = 1;
    else if (granted && s.rvalid) granted = 0;
    if (!stall) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (lu || s.redir) pipe[0] = '{default: 0};
      else pipe[0] = '{v: s.v, rd: s.rd, we: s.we, ld: s.ld, st: s.st, rs1: s.rs1, rs2: s.rs2};
    end
  endfunction

  // One cycle: drive at negedge, check mid-low phase, clock, return at next negedge
  task automatic step(input stim_t s, input bit has_tab, input exp_t te, input string tag);
    exp_t me;
    drive(s);
    #1;
    me = model_out(s);
    chk_all({tag, "/model"}, me);
    if (has_tab) chk_all({tag, "/table"}, te);
    model_update(s);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk_all("reset_hold", ex(0, ALL, 2'b00, 0, 0));
    model_clear();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  vec_t  tab [$];
  exp_t  rst_exp;
  exp_t  dummy;
  stim_t s;
  string nm;

  initial begin
    rst_exp = ex(0, ALL, 2'b00, 0, 0);
    dummy   = rst_exp;
    rst_ni  = 1'b0;
    drive(nop(0, 0));
    model_clear();

    // Forwarding from MEM and WB, x0 producer
    tab.push_back('{ins(1, 3, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 4, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 5, 3, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 1, 1)});
    tab.push_back('{ins(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 2, 0)});
    tab.push_back('{ins(1, 8, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(0, ALL, 2'b00, 0, 0)});
    // Load-use bubble, load handshake, WB forward, spurious rvalid
    tab.push_back('{ins(1, 5, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, LU, 2'b01, 0, 0)});
    tab.push_back('{ins(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0), ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), ex(0, NONE, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 6, 5, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 1),                                  ex(0, ALL, 2'b00, 2, 0)});
    // Redirect beats load-use
    tab.push_back('{ins(1, 9, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 10, 9, 9, 1, 1, 1, 0, 0, 0, 1, 0, 0), ex(0, ALL, 2'b11, 0, 0)});
    tab.push_back('{nop(1, 0),                                  ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 1),                                  ex(0, ALL, 2'b00, 0, 0)});
    // JAL, then a store whose grant arrives after three wait cycles
    tab.push_back('{ins(1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), ex(0, ALL, 2'b10, 0, 0)});
    tab.push_back('{ins(1, 0, 2, 3, 1, 1, 0, 0, 1, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{nop(1, 0),                                  ex(1, ALL, 2'b00, 0, 0)});
    // Jump colliding with load-use is retried after the load completes
    tab.push_back('{ins(1, 2, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), ex(0, ALL, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 1, 2, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0), ex(0, LU, 2'b01, 0, 0)});
    tab.push_back('{ins(1, 1, 2, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0), ex(1, NONE, 2'b00, 0, 0)});
    tab.push_back('{ins(1, 1, 2, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1), ex(0, ALL, 2'b10, 0, 0)});
    tab.push_back('{nop(0, 0),                                  ex(0, ALL, 2'b00, 2, 0)});

    @(negedge clk);
    chk_all("reset", rst_exp);
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (tab[i]) begin
      nm = $sformatf("vec%0d", i);
      step(tab[i].s, 1'b1, tab[i].e, nm);
    end

    // Reset while waiting for a load grant abandons the transaction
    step(ins(1, 4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, dummy, "rg0");
    step(nop(0, 0), 1'b0, dummy, "rg1");
    step(nop(0, 0), 1'b1, ex(1, NONE, 2'b00, 0, 0), "rg_idle_wait");
    step(nop(0, 0), 1'b1, ex(1, NONE, 2'b00, 0, 0), "rg_wait_gnt");
    drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    rst_ni = 1'b0;
    #1;
    chk_all("rst_in_wait_gnt", rst_exp);
    model_clear();
    @(negedge clk);
    rst_ni = 1'b1;
    drive(nop(0, 0));
    #1;
    chk_all("rst_release", rst_exp);
    @(negedge clk);
    // Fresh load after reset: granted at once, data one cycle later
    step(ins(1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, dummy, "pr0");
    step(nop(0, 0), 1'b0, dummy, "pr1");
    step(nop(1, 0), 1'b1, ex(1, NONE, 2'b00, 0, 0), "pr_gnt");
    step(nop(0, 1), 1'b1, ex(0, ALL, 2'b00, 0, 0), "pr_rvalid");

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int kind;
      if ($urandom_range(399) == 0) begin
        do_reset();
      end
      kind     = $urandom_range(3);
      s.v      = $urandom_range(3) != 0;
      s.rd     = $urandom_range(3);
      s.rs1    = $urandom_range(3);
      s.rs2    = $urandom_range(3);
      s.u1     = 1'($urandom_range(1));
      s.u2     = 1'($urandom_range(1));
      s.ld     = (kind == 0);
      s.st     = (kind == 1);
      s.we     = !s.st;
      s.jmp    = $urandom_range(7) == 0;
      s.redir  = $urandom_range(7) == 0;
      s.gnt    = 1'($urandom_range(1));
      s.rvalid = $urandom_range(4) < 2;
      step(s, 1'b0, dummy, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline sequencing controller for the five-stage core (IF, ID, EX, MEM, WB). It consumes per-instruction decode information from the control unit. It keeps a shadow pipeline of destination and source registers, and from that drives:
- stage-register write enables and flushes,
- EX operand forwarding selects,
- the data-memory request/grant/rvalid handshake.

It resolves load-use, control-transfer and memory-wait hazards so that the datapath registers only need enable and flush inputs.

## Interface
- ADDR_WIDTH, 5, register index width
- clk_i  in  1  core clock
- rst_ni  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i / id_rs2_i  in  ADDR_WIDTH  ID source register indices
- id_rs1_used_i / id_rs2_used_i  in  1  source actually read
- id_rd_i  in  ADDR_WIDTH  ID destination index
- id_we_i  in  1  ID instruction writes rd
- id_load_i / id_store_i  in  1  ID instruction is load / store
- id_jump_i  in  1  JAL resolved in ID
- ex_redirect_i  in  1  taken branch or JALR resolved in EX
- dmem_gnt_i  in  1  data memory accepted request
- dmem_rvalid_i  in  1  load data valid
- dmem_req_o  out  1  data memory request
- pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o  out  1  stage register enables
- if_id_flush_o, id_ex_flush_o  out  1  load bubble into stage register (takes precedence over its enable)
- fwd_a_o / fwd_b_o  out  2  EX operand source: 0 = register file, 1 = MEM ALU result, 2 = WB write data

## Operation
- Shadow registers per stage, each tracking valid, rd, we, load, store:
  - ex_*, mem_*, wb_*.
  - ex_rs1 / ex_rs2 plus their used flags.
- mem_stall: pipeline frozen by the memory FSM.
  - All enables are 0 and no flushes are asserted.
  - The shadow pipeline holds.
- When not mem_stall, the shadow advances:
  - wb ← mem; mem ← ex.
  - ex ← ID info, or a bubble (valid = 0) if load_use or ex_redirect_i.
- load_use hazard:
  - Condition: ex_valid && ex_load && ex_rd != 0 && id_valid_i && (rs1_used && rs1 == ex_rd || rs2_used && rs2 == ex_rd).
  - Response: pc_we_o = 0, if_id_we_o = 0, id_ex_flush_o = 1, rest enabled.
- ex_redirect_i (priority over load_use):
  - if_id_flush_o = 1, id_ex_flush_o = 1, pc_we_o = 1 (datapath loads the target).
- id_jump_i without ex_redirect_i:
  - if_id_flush_o = 1; the JAL itself advances to EX.
  - If load_use is also present, load_use wins and the jump is retried next cycle.
- Forwarding for the EX instruction; rd = 0 never forwards:
  - 1 when mem_valid && mem_we && !mem_load && mem_rd == ex_rs.
  - Otherwise 2 when wb_valid && wb_we && wb_rd == ex_rs.
  - Otherwise 0. MEM has priority over WB.
- Memory FSM states are IDLE, WAIT_GNT, WAIT_RVALID. memop = mem_valid && (mem_load || mem_store).
  - IDLE, memop:
    - dmem_req_o = 1.
    - Store with gnt: completes with no stall.
    - Load with gnt: go to WAIT_RVALID, stall.
    - No gnt: go to WAIT_GNT, stall.
  - WAIT_GNT:
    - dmem_req_o = 1, stall.
    - On gnt: a store releases the stall this cycle and goes to IDLE; a load goes to WAIT_RVALID.
  - WAIT_RVALID:
    - dmem_req_o = 0.
    - Stall until the dmem_rvalid_i cycle, which releases the stall and returns to IDLE.
  - dmem_rvalid_i outside WAIT_RVALID is ignored.
- While mem_stall, ex_redirect_i and id_jump_i are held by the datapath and acted on in the first non-stalled cycle.

## Timing
- Single clock domain.
- All outputs are combinational from state plus the current inputs.
- Async reset clears every shadow valid and the FSM to IDLE.
- Output values in reset:
  - All enables 1, flushes 0, fwd 0, dmem_req_o 0.
- Load-use costs 1 bubble; the dependent instruction then sees fwd = 2 from WB.
- Redirect costs 2 bubbles; JAL costs 1 bubble.
- Minimum load occupancy in MEM is 2 cycles: gnt cycle, then rvalid at earliest the next cycle.
- Reset asserted mid-transaction abandons it; dmem_req_o drops immediately.

## Test plan
- ADD x3 in EX and SUB using x3,x3 in ID, next cycle → fwd_a = fwd_b = 1; following instruction using x3 → fwd = 2; rd = x0 producer → fwd = 0.
- LW x5 in EX, ADD x6,x5,x1 in ID → one cycle of pc_we = 0, if_id_we = 0, id_ex_flush = 1; two cycles later the ADD is in EX with fwd_a = 2.
- BEQ taken (ex_redirect = 1) while a load-use condition is present → if_id_flush = id_ex_flush = 1, pc_we = 1, no stall.
- Store with gnt delayed 3 cycles → dmem_req held 1 for 4 cycles, all enables 0 for 3 cycles, released in the gnt cycle.
- Load with gnt immediate, rvalid after 2 cycles → stall during WAIT_RVALID, released in the rvalid cycle, FSM back to IDLE; spurious rvalid in IDLE → no effect.
- rst_ni pulsed low in WAIT_GNT → dmem_req = 0 at once; all enables 1 and FSM IDLE after release.
